// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding, BCD digit width, digit increment helper.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam int NDIG  = 4;

  typedef enum logic [2:0] {
    EDIT  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  // Out-of-range codes fold to 0 so a digit can never exceed 9.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_W'(9)) ? '0 : d + BCD_W'(1);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// User-control and display bundle of the countdown timer: button pulses in, BCD digits and status out.
interface countdown_timer_ctrl_if;
  logic        inc_pulse;
  logic        nxt_pulse;
  logic [15:0] digits;
  logic [1:0]  edit_sel;
  logic [2:0]  state;
  logic        running;
  logic        alarm;

  modport master (
    output inc_pulse, nxt_pulse,
    input  digits, edit_sel, state, running, alarm
  );

  modport slave (
    input  inc_pulse, nxt_pulse,
    output digits, edit_sel, state, running, alarm
  );
endinterface

// File: rtl/bcd_down4.sv
// Combinational 4-digit BCD decrement with borrow chain; zero flags a 0000 result.
module bcd_down4
  import timer_pkg::*;
(
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        zero
);

  logic             borrow;
  logic [BCD_W-1:0] dig;

  always_comb begin
    borrow = 1'b1;
    dig    = '0;
    dout   = '0;
    for (int i = 0; i < NDIG; i++) begin
      dig = din[i*BCD_W +: BCD_W];
      if (borrow) begin
        if (dig == '0) begin
          dout[i*BCD_W +: BCD_W] = BCD_W'(9);
        end else begin
          dout[i*BCD_W +: BCD_W] = dig - BCD_W'(1);
          borrow = 1'b0;
        end
      end else begin
        dout[i*BCD_W +: BCD_W] = dig;
      end
    end
    zero = (dout == '0);
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Four-digit BCD countdown timer: edit digits, run/pause, alarm in DONE.
// Define TIMER_ALARM_EN for an alarm lasting ALARM_TICKS ticks; otherwise alarm is a single cycle.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int TICK_HZ     = 10,
  parameter int ALARM_TICKS = 20
) (
  input logic                  clk,
  input logic                  nRst,
  countdown_timer_ctrl_if.slave io
);

  localparam int PRESC_MAX = CLK_HZ / TICK_HZ;
  localparam int PW        = ($clog2(PRESC_MAX) < 1) ? 1 : $clog2(PRESC_MAX);
  localparam logic [PW-1:0] PRESC_TERM = PW'(PRESC_MAX - 1);

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [1:0]    edit_sel_q, edit_sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;

  logic          tick;
  logic [15:0]   dec_val;
  logic          dec_zero;

`ifdef TIMER_ALARM_EN
  localparam int AW = ($clog2(ALARM_TICKS + 1) < 1) ? 1 : $clog2(ALARM_TICKS + 1);
  logic [AW-1:0] alm_cnt_q, alm_cnt_d;
`endif

  bcd_down4 u_dec (
    .din  (digits_q),
    .dout (dec_val),
    .zero (dec_zero)
  );

  assign tick = (presc_q == PRESC_TERM);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    edit_sel_d = edit_sel_q;
    presc_d    = presc_q;
`ifdef TIMER_ALARM_EN
    alm_cnt_d  = alm_cnt_q;
`endif
    case (state_q)
      EDIT: begin
        if (io.nxt_pulse) begin
          if (edit_sel_q == 2'd3) begin
            edit_sel_d = 2'd0;
            if (digits_q != '0) begin
              state_d = RUN;
              presc_d = '0;
            end
          end else begin
            edit_sel_d = edit_sel_q + 2'd1;
          end
        end else if (io.inc_pulse) begin
          digits_d[edit_sel_q*BCD_W +: BCD_W] = bcd_inc(digits_q[edit_sel_q*BCD_W +: BCD_W]);
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A tick landing on the pause request still decrements; reaching zero beats the pause.
        if (tick) begin
          digits_d = dec_val;
          if (dec_zero) begin
            state_d = DONE;
`ifdef TIMER_ALARM_EN
            alm_cnt_d = '0;
`endif
          end else if (io.nxt_pulse) begin
            state_d = PAUSE;
          end
        end else if (io.nxt_pulse) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (io.nxt_pulse) begin
          state_d = RUN;
        end else if (io.inc_pulse) begin
          state_d    = EDIT;
          edit_sel_d = 2'd0;
        end
      end
      DONE: begin
`ifdef TIMER_ALARM_EN
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (io.inc_pulse || io.nxt_pulse ||
            (tick && alm_cnt_q == AW'(ALARM_TICKS - 1))) begin
          state_d    = EDIT;
          edit_sel_d = 2'd0;
          presc_d    = '0;
          alm_cnt_d  = '0;
        end else if (tick) begin
          alm_cnt_d = alm_cnt_q + AW'(1);
        end
`else
        state_d    = EDIT;
        edit_sel_d = 2'd0;
        presc_d    = '0;
`endif
      end
      default: begin
        state_d    = EDIT;
        edit_sel_d = 2'd0;
        presc_d    = '0;
      end
    endcase
    running_d = (state_d == RUN);
    alarm_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q    <= EDIT;
      digits_q   <= '0;
      edit_sel_q <= 2'd0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
`ifdef TIMER_ALARM_EN
      alm_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      edit_sel_q <= edit_sel_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      alarm_q    <= alarm_d;
`ifdef TIMER_ALARM_EN
      alm_cnt_q  <= alm_cnt_d;
`endif
    end
  end

  assign io.digits   = digits_q;
  assign io.edit_sel = edit_sel_q;
  assign io.state    = state_q;
  assign io.running  = running_q;
  assign io.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with a tick every 10 cycles and a 3-tick alarm.
module tb_countdown_timer_ctrl;
  import timer_pkg::*;

  logic clk;
  logic nRst;
  int   tests;
  int   fails;

  countdown_timer_ctrl_if bus ();

  countdown_timer_ctrl #(
    .CLK_HZ      (100),
    .TICK_HZ     (10),
    .ALARM_TICKS (3)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic inc, input logic nxt);
    bus.inc_pulse = inc;
    bus.nxt_pulse = nxt;
    cyc(1);
    bus.inc_pulse = 1'b0;
    bus.nxt_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset, then key in a 4-digit BCD value, leaving edit_sel at 3.
  task automatic load(input logic [15:0] val);
    nRst = 1'b1;
    cyc(1);
    nRst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      repeat (int'(val[d*4 +: 4])) pulse(1'b1, 1'b0);
      if (d < 3) pulse(1'b0, 1'b1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nRst  = 1'b1;
    bus.inc_pulse = 1'b0;
    bus.nxt_pulse = 1'b0;
    cyc(2);
    nRst = 1'b0;

    chk("rst_state",   32'(bus.state),    32'd0);
    chk("rst_digits",  32'(bus.digits),   32'h0);
    chk("rst_sel",     32'(bus.edit_sel), 32'd0);
    chk("rst_running", 32'(bus.running),  32'd0);
    chk("rst_alarm",   32'(bus.alarm),    32'd0);

    // Edit: three increments on digit 0, advance, twelve on digit 1 (wraps past 9)
    repeat (3) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    repeat (12) pulse(1'b1, 1'b0);
    chk("edit_digits", 32'(bus.digits),   32'h0023);
    chk("edit_sel",    32'(bus.edit_sel), 32'd1);

    // Zero start is refused
    load(16'h0000);
    chk("zero_sel3", 32'(bus.edit_sel), 32'd3);
    pulse(1'b0, 1'b1);
    chk("zero_state",   32'(bus.state),    32'd0);
    chk("zero_sel",     32'(bus.edit_sel), 32'd0);
    chk("zero_running", 32'(bus.running),  32'd0);

    // Borrow through three digits; inc is ignored while running
    load(16'h1000);
    chk("brw_loaded", 32'(bus.digits), 32'h1000);
    pulse(1'b0, 1'b1);
    chk("brw_state",   32'(bus.state),   32'd1);
    chk("brw_running", 32'(bus.running), 32'd1);
    pulse(1'b1, 1'b0);
    cyc(8);
    chk("brw_pre_tick", 32'(bus.digits), 32'h1000);
    cyc(1);
    chk("brw_10", 32'(bus.digits), 32'h0999);
    cyc(10);
    chk("brw_20", 32'(bus.digits), 32'h0998);

    // Finish from 0002
    load(16'h0002);
    pulse(1'b0, 1'b1);
    cyc(10);
    chk("fin_10", 32'(bus.digits), 32'h0001);
    cyc(10);
    chk("fin_digits",  32'(bus.digits),  32'h0000);
    chk("fin_state",   32'(bus.state),   32'd3);
    chk("fin_alarm",   32'(bus.alarm),   32'd1);
    chk("fin_running", 32'(bus.running), 32'd0);
`ifdef TIMER_ALARM_EN
    cyc(29);
    chk("alm_hold_state", 32'(bus.state), 32'd3);
    chk("alm_hold",       32'(bus.alarm), 32'd1);
    cyc(1);
    chk("alm_end_state", 32'(bus.state), 32'd0);
    chk("alm_end",       32'(bus.alarm), 32'd0);
    // A pulse cuts the alarm short
    load(16'h0001);
    pulse(1'b0, 1'b1);
    cyc(10);
    chk("alm_cut_pre", 32'(bus.alarm), 32'd1);
    pulse(1'b1, 1'b0);
    chk("alm_cut_state", 32'(bus.state), 32'd0);
    chk("alm_cut",       32'(bus.alarm), 32'd0);
`else
    cyc(1);
    chk("alm_end_state", 32'(bus.state),    32'd0);
    chk("alm_end",       32'(bus.alarm),    32'd0);
    chk("alm_end_sel",   32'(bus.edit_sel), 32'd0);
`endif

    // Pause request on a tick cycle: decrement applies, then pause
    load(16'h0005);
    pulse(1'b0, 1'b1);
    cyc(9);
    pulse(1'b0, 1'b1);
    chk("col_digits", 32'(bus.digits), 32'h0004);
    chk("col_state",  32'(bus.state),  32'd2);
    cyc(15);
    chk("pause_frozen", 32'(bus.digits), 32'h0004);
    pulse(1'b1, 1'b1);
    chk("resume_state",  32'(bus.state),  32'd1);
    chk("resume_digits", 32'(bus.digits), 32'h0004);
    cyc(9);
    chk("resume_pre_tick", 32'(bus.digits), 32'h0004);
    cyc(1);
    chk("resume_tick", 32'(bus.digits), 32'h0003);
    pulse(1'b0, 1'b1);
    chk("pause2_state", 32'(bus.state), 32'd2);
    pulse(1'b1, 1'b0);
    chk("pause_edit_state",  32'(bus.state),    32'd0);
    chk("pause_edit_sel",    32'(bus.edit_sel), 32'd0);
    chk("pause_edit_digits", 32'(bus.digits),   32'h0003);

    // Tick with pause request reaching zero: DONE wins
    load(16'h0001);
    pulse(1'b0, 1'b1);
    cyc(9);
    pulse(1'b0, 1'b1);
    chk("donewin_state",  32'(bus.state),  32'd3);
    chk("donewin_digits", 32'(bus.digits), 32'h0000);

    // Mid-run reset
    load(16'h0050);
    pulse(1'b0, 1'b1);
    cyc(5);
    chk("mid_running", 32'(bus.running), 32'd1);
    nRst = 1'b1;
    cyc(1);
    nRst = 1'b0;
    chk("mid_state",   32'(bus.state),    32'd0);
    chk("mid_digits",  32'(bus.digits),   32'h0);
    chk("mid_sel",     32'(bus.edit_sel), 32'd0);
    chk("mid_running0", 32'(bus.running), 32'd0);
    chk("mid_alarm",   32'(bus.alarm),    32'd0);
    cyc(12);
    chk("mid_stay_state", 32'(bus.state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, input clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 10, countdown decrement rate.
REQ-003 SHALL have parameter ALARM_TICKS, default 20, alarm duration in ticks.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port nRst  input  1  reset, synchronous, active-high (1 = reset).
REQ-006 SHALL have port inc_pulse  input  1  one-cycle pulse, already debounced and edge-detected.
REQ-007 SHALL have port nxt_pulse  input  1  one-cycle pulse, already debounced and edge-detected.
REQ-008 SHALL have port digits  output  16  four BCD digits; [3:0] least significant, [15:12] most significant.
REQ-009 SHALL have port edit_sel  output  2  digit under edit (0 = LSD).
REQ-010 SHALL have port state  output  3  current FSM state encoding.
REQ-011 SHALL have port running  output  1  high in RUN.
REQ-012 SHALL have port alarm  output  1  high in DONE.

Function
REQ-013 SHALL implement states EDIT, RUN, PAUSE, DONE; all outputs registered.
REQ-014 In EDIT, inc_pulse SHALL increment the selected digit, wrapping 9->0; other digits unchanged.
REQ-015 In EDIT, nxt_pulse SHALL advance edit_sel 0->1->2->3; at edit_sel=3, nxt_pulse SHALL go to RUN if digits != 0000, else stay in EDIT with edit_sel=0.
REQ-016 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1, asserting internal tick at the terminal count; it SHALL clear on RUN entry, so the first decrement occurs exactly CLK_HZ/TICK_HZ cycles after entry.
REQ-017 In RUN, each tick SHALL decrement digits as a 4-digit BCD value with borrow (x0 -> (x-1)9; 1000 -> 0999).
REQ-018 A tick producing 0000 SHALL enter DONE on the same edge the digits become 0000.
REQ-019 In RUN, nxt_pulse SHALL enter PAUSE; prescaler and digits freeze.
REQ-020 In PAUSE, nxt_pulse SHALL return to RUN, with the prescaler resuming from its frozen value; inc_pulse SHALL enter EDIT with edit_sel=0 and digits kept.
REQ-021 In RUN, inc_pulse SHALL be ignored.
REQ-022 If inc_pulse and nxt_pulse are high in the same cycle, nxt_pulse SHALL win and inc_pulse SHALL be discarded.
REQ-023 If a tick coincides with nxt_pulse in RUN, the decrement SHALL apply and the state SHALL go to PAUSE, or to DONE if the result is 0000 (DONE wins).
REQ-024 Digits SHALL never hold values above 9.

Reset
REQ-025 While nRst=1 at a clock edge: state=EDIT, digits=0000, edit_sel=0, prescaler=0, alarm counter=0, running=0, alarm=0.
REQ-026 Reset SHALL override all pulses and any in-progress count, including assertion mid-RUN and mid-DONE.

Configuration
REQ-027 With TIMER_ALARM_EN defined, DONE SHALL hold alarm=1 for ALARM_TICKS ticks (prescaler free-running in DONE) or until any pulse, whichever is first, then enter EDIT with edit_sel=0.
REQ-028 Without TIMER_ALARM_EN, alarm SHALL be 1 for exactly one cycle in DONE, then the state SHALL enter EDIT; the alarm counter SHALL not be built.

Structure
REQ-029 A shared package timer_pkg SHALL hold the state enum (EDIT=0, RUN=1, PAUSE=2, DONE=3) and the BCD digit width constant (4).
REQ-030 The BCD borrow chain SHALL be the sub-module bcd_down4 (16-bit in, 16-bit out, zero flag), combinational, instantiated once.
REQ-031 Prescaler width SHALL be $clog2(CLK_HZ/TICK_HZ).

Verification (CLK_HZ=100, TICK_HZ=10, so a tick every 10 cycles; ALARM_TICKS=3)
REQ-032 Edit: reset; inc x3; nxt; inc x12 -> digits=0x0023, edit_sel=1.
REQ-033 Borrow: load 0x1000, nxt to RUN; after 10 cycles digits=0x0999; after 20 cycles digits=0x0998.
REQ-034 Zero start: digits=0000, nxt at edit_sel=3 -> state stays EDIT, edit_sel=0, running=0.
REQ-035 Finish: RUN from 0x0002; 20 cycles later digits=0000 and state=DONE; with TIMER_ALARM_EN, alarm high 30 cycles then EDIT; without it, alarm high 1 cycle.
REQ-036 Pause/collision: nxt on a tick cycle at 0x0005 -> digits=0x0004, state=PAUSE; inc+nxt in the same cycle in PAUSE -> RUN, digits unchanged.
REQ-037 Mid-run reset: nRst=1 for 1 cycle during RUN -> next cycle all outputs at reset values, state=EDIT.
